// File: rtl/xcorr_sweep_ctrl_pkg.sv
// Shared definitions for the cross-correlation sweep sequencer and for the
// sample-buffer and multiplier wrappers that sit around it.
package xcorr_pkg;

    // Default datapath widths
    localparam int ADDR_W  = 10;
    localparam int PROD_W  = 32;
    localparam int ACC_W   = 48;

    // Fixed latencies of the surrounding blocks; the wrappers use these too
    localparam int RD_LAT  = 1;
    localparam int MUL_LAT = 3;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SWEEP = 3'd1,
        DRAIN = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/xcorr_sweep_ctrl_if.sv
// Bundle between the sweep sequencer (master) and its environment (slave):
// the control pulse pair, the two buffer read addresses, the multiplier
// product stream, the published result and the sequencer state for debug.
//
// Handshake: there is no valid/ready pair on this bundle. `start` is a
// one-cycle request that is accepted only while `busy` is low (IDLE) and is
// dropped otherwise. Each address pair leaves with an implicit valid in
// SWEEP; its product must appear on `prod` exactly RD_LAT+MUL_LAT cycles
// later, with no stall. `done` is a one-cycle pulse marking new results.
interface xcorr_sweep_ctrl_if
    import xcorr_pkg::*;
#(
    parameter int ADDR_W = xcorr_pkg::ADDR_W,
    parameter int PROD_W = xcorr_pkg::PROD_W,
    parameter int ACC_W  = xcorr_pkg::ACC_W
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        mem1_addr;
    logic [ADDR_W-1:0]        mem2_addr;
    logic signed [PROD_W-1:0] prod;
    logic [ADDR_W-1:0]        best_lag;
    logic signed [ACC_W-1:0]  best_score;
    state_t                   state;

    modport master (
        input  start, prod,
        output busy, done, mem1_addr, mem2_addr, best_lag, best_score, state
    );

    modport slave (
        output start, prod,
        input  busy, done, mem1_addr, mem2_addr, best_lag, best_score, state
    );
endinterface

// File: rtl/xcorr_valid_pipe.sv
// Delay line that follows each issued address pair through the buffer read
// and the multiplier, so the accumulator knows when a product is real and
// which product closes the current lag.
module xcorr_valid_pipe
    import xcorr_pkg::*;
#(
    parameter int LEN = RD_LAT + MUL_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    input  logic last_in,
    output logic valid_out,
    output logic last_out
);
    logic [LEN-1:0] valid_sr;
    logic [LEN-1:0] last_sr;

    // Shift both tokens one stage per clock; cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr[0] <= valid_in;
            last_sr[0]  <= last_in;
            for (int i = 1; i < LEN; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign valid_out = valid_sr[LEN-1];
    assign last_out  = last_sr[LEN-1];
endmodule

// File: rtl/xcorr_sweep_ctrl.sv
// Cross-correlation sweep sequencer: for every lag it streams N_SAMPLES
// address pairs to the two sample buffers, sums the returning products,
// keeps the best (lag, score) and publishes it once the sweep completes.
module xcorr_sweep_ctrl
    import xcorr_pkg::*;
#(
    parameter int ADDR_W    = xcorr_pkg::ADDR_W,
    parameter int N_SAMPLES = 1024,
    parameter int MAX_LAG   = 1023,
    parameter int RD_LAT    = xcorr_pkg::RD_LAT,
    parameter int MUL_LAT   = xcorr_pkg::MUL_LAT,
    parameter int PROD_W    = xcorr_pkg::PROD_W,
    parameter int ACC_W     = xcorr_pkg::ACC_W
) (
    input  logic                clk,
    input  logic                rst_n,
    xcorr_sweep_ctrl_if.master  bus
);
    localparam int PIPE_LEN = RD_LAT + MUL_LAT;
    // One extra bit so N_SAMPLES = 2^ADDR_W is representable
    localparam int IDX_W    = ADDR_W + 1;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q;
    logic [ADDR_W-1:0]        lag_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  run_score_q;
    logic [ADDR_W-1:0]        run_lag_q;
    logic signed [ACC_W-1:0]  best_score_q;
    logic [ADDR_W-1:0]        best_lag_q;

    logic                     last_sample;
    logic                     last_lag;
    logic                     tok_valid;
    logic                     tok_last;
    logic signed [ACC_W-1:0]  prod_ext;

    assign last_sample = (idx_q == IDX_W'(N_SAMPLES - 1));
    assign last_lag    = (lag_q == ADDR_W'(MAX_LAG));
    assign prod_ext    = {{(ACC_W - PROD_W){bus.prod[PROD_W-1]}}, bus.prod};

    xcorr_valid_pipe #(.LEN(PIPE_LEN)) u_valid_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (state_q == SWEEP),
        .last_in   ((state_q == SWEEP) && last_sample),
        .valid_out (tok_valid),
        .last_out  (tok_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DRAIN ends when the last product of the lag arrives
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)   state_d = SWEEP;
            SWEEP:   if (last_sample) state_d = DRAIN;
            DRAIN:   if (tok_last)    state_d = CMP;
            CMP:     state_d = last_lag ? DONE : SWEEP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sample index within the lag and the lag counter itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            lag_q <= '0;
        end else begin
            idx_q <= (state_q == SWEEP) ? idx_q + 1'b1 : '0;
            if (state_q == IDLE)
                lag_q <= '0;
            else if (state_q == CMP && !last_lag)
                lag_q <= lag_q + 1'b1;
        end
    end

    // Product accumulator, cleared as each lag's SWEEP begins; wraps freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else if (state_d == SWEEP && state_q != SWEEP)
            acc_q <= '0;
        else if (tok_valid)
            acc_q <= acc_q + prod_ext;
    end

    // Running peak: lag 0 seeds it, later lags must be strictly larger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_score_q <= '0;
            run_lag_q   <= '0;
        end else if (state_q == CMP && (lag_q == '0 || acc_q > run_score_q)) begin
            run_score_q <= acc_q;
            run_lag_q   <= lag_q;
        end
    end

    // Published result, refreshed only when a sweep completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_score_q <= '0;
            best_lag_q   <= '0;
        end else if (state_q == DONE) begin
            best_score_q <= run_score_q;
            best_lag_q   <= run_lag_q;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.mem1_addr  = (state_q == SWEEP) ? idx_q[ADDR_W-1:0] : '0;
    assign bus.mem2_addr  = (state_q == SWEEP) ? lag_q + idx_q[ADDR_W-1:0] : '0;
    assign bus.best_lag   = best_lag_q;
    assign bus.best_score = best_score_q;
    assign bus.state      = state_q;
endmodule

// File: doc/xcorr_sweep_ctrl.md
# xcorr_sweep_ctrl

- Sequencer for the microphone-pair cross-correlation datapath: on `start`, sweeps every lag, drives the two sample-buffer read ports and accumulates the external multiplier's products.
- Keeps the peak-correlation lag and publishes it, with its score, to the arcsin angle lookup.
- Sits between the dual-port sample buffers and the pipelined multiplier on one side, and the angle ROM on the other.

## Interface
Parameters:
- `ADDR_W`, 10: sample-buffer address width; buffer depth is 2^ADDR_W.
- `N_SAMPLES`, 1024: products summed per lag, 1..2^ADDR_W.
- `MAX_LAG`, 1023: last lag swept; lags run 0..MAX_LAG.
- `RD_LAT`, 1: buffer read latency in cycles.
- `MUL_LAT`, 3: multiplier latency in cycles.
- `PROD_W`, 32: product width (signed).
- `ACC_W`, 48: accumulator and score width (signed).

Ports:
- `clk`, in, 1: single clock, all logic on rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle request to begin a sweep.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse when results update.
- `mem1_addr`, out, ADDR_W: reference-channel read address.
- `mem2_addr`, out, ADDR_W: delayed-channel read address.
- `prod`, in, PROD_W: multiplier output, signed.
- `best_lag`, out, ADDR_W: lag with the maximum score from the last completed sweep.
- `best_score`, out, ACC_W: that score.

## Operation
- States:
  - IDLE → SWEEP on `start`.
  - SWEEP issues N_SAMPLES address pairs, then → DRAIN.
  - DRAIN waits RD_LAT+MUL_LAT cycles, then → CMP.
  - CMP lasts 1 cycle: if lag==MAX_LAG → DONE, else lag+1 → SWEEP.
  - DONE lasts 1 cycle, then → IDLE.
- Addresses in SWEEP, sample index i = 0..N_SAMPLES-1:
  - mem1_addr = i.
  - mem2_addr = (lag + i) mod 2^ADDR_W. Circular correlation; the wrap is intentional.
- Outside SWEEP, both addresses hold 0.
- Valid tracking:
  - A valid token enters a delay line of length RD_LAT+MUL_LAT each SWEEP cycle.
  - When a token exits, `acc += sign_extend(prod)`.
  - `acc` clears on entering SWEEP for each lag.
- Accumulator arithmetic: signed, ACC_W bits, wraps on overflow (no saturation). The defaults cannot overflow.
- Peak tracking in CMP:
  - Lag 0 loads the running best unconditionally.
  - Later lags replace it only if acc > running best (strict, signed).
  - Ties keep the lowest lag.
- `best_lag`/`best_score` are copied from the running best in DONE and held until the next DONE. A sweep in progress never disturbs them.
- `start` is ignored while `busy`. `start` in the same cycle as DONE is also ignored.
- `busy` = state ≠ IDLE. `done` is high only in DONE.

## Timing
- Reset values: all outputs 0; state IDLE; lag, acc, running best and delay line cleared.
- Reset asserted mid-sweep aborts the sweep immediately with no `done`. `best_*` return to 0.
- `start` sampled high in IDLE: `busy` rises the next cycle, and the first address pair is presented in that same cycle.
- Per lag: N_SAMPLES + RD_LAT + MUL_LAT + 1 cycles.
- `done` is high exactly (MAX_LAG+1)·(N_SAMPLES+RD_LAT+MUL_LAT+1) + 1 cycles after the `start` edge. `busy` falls the cycle after `done`.
- `prod` is consumed RD_LAT+MUL_LAT cycles after its addresses are issued. The multiplier must be fully pipelined with no stall.

## Structure
- Package `xcorr_pkg`:
  - State enum: IDLE, SWEEP, DRAIN, CMP, DONE.
  - Default width constants: ADDR_W, PROD_W, ACC_W.
  - Latency constants RD_LAT and MUL_LAT, shared with the buffer and multiplier wrappers.
- One sub-module, `xcorr_valid_pipe`: a parameterised-length shift register carrying the valid token and a last-sample tag.
- The FSM, address counters, accumulator and peak registers stay in the top module.

## Test plan
Bench settings: N_SAMPLES=16, MAX_LAG=15, ADDR_W=4; behavioural buffers and multiplier at the stated latencies.
- Impulses: mem1[0]=1, mem2[5]=1, rest 0 → `best_lag`=5, `best_score`=1; `done` exactly 16·21+1=337 cycles after `start`.
- Wrap: mem1[3]=2, mem2[1]=3 → match at lag 14 ((14+3) mod 16 = 1) → `best_lag`=14, `best_score`=6.
- Ties and negatives: all zeros → lag 0, score 0. Then mem1 all 1, mem2 all −1 → every lag scores −16 → `best_lag`=0, `best_score`=−16.
- Busy protection: pulse `start` again at cycle 100 of a sweep → no restart, a single `done` at cycle 337, results identical to the unperturbed run.
- Reset mid-sweep: assert `rst_n`=0 at cycle 150 → all outputs 0 within the same cycle, no `done`. A new `start` after release completes correctly.
- Result hold: a second sweep with new data → `best_*` keep the previous values until its `done`, then update.
